// File: rtl/lane_scroll_renderer.sv
`default_nettype none
// ============================================================================
// Module      : lane_scroll_renderer
// Description : Holds LANES vertical bit-columns of ROWS cells each. A scroll
//               tick shifts every lane down one row and injects new cells at
//               row 0, then one full frame of pixel writes is streamed out.
//               Also handles deferred/overrun ticks, bottom-exit reporting,
//               clear, and frame-done signalling.
// Ports       : clock        - system clock
//               resetn       - synchronous active-low reset
//               tick         - one-cycle scroll strobe
//               spawn        - cells injected at row 0 (sampled with tick)
//               clear        - empty all lanes and redraw
//               x, y, colour - pixel coordinates and colour
//               plot         - pixel write enable
//               frame_done   - pulse after the last pixel of a frame
//               hit_bottom   - per-lane pulse when an occupied bottom cell exits
//               tick_overrun - pulse when a tick is dropped
// Revision    : 1.0 - initial release
// ============================================================================
module lane_scroll_renderer #(
    parameter int         LANES      = 3,
    parameter int         ROWS       = 120,
    parameter int         LANE_W     = 8,
    parameter int         X0         = 50,
    parameter int         X_PITCH    = 26,
    parameter logic [2:0] ON_COLOUR  = 3'b100,
    parameter logic [2:0] OFF_COLOUR = 3'b000
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             tick,
    input  logic [LANES-1:0] spawn,
    input  logic             clear,
    output logic [7:0]       x,
    output logic [6:0]       y,
    output logic [2:0]       colour,
    output logic             plot,
    output logic             frame_done,
    output logic [LANES-1:0] hit_bottom,
    output logic             tick_overrun
);

    localparam int LW = (LANES  > 1) ? $clog2(LANES)  : 1;
    localparam int RW = (ROWS   > 1) ? $clog2(ROWS)   : 1;
    localparam int CW = (LANE_W > 1) ? $clog2(LANE_W) : 1;

    localparam logic [LW-1:0] c_LANE_LAST = LW'(LANES - 1);
    localparam logic [RW-1:0] c_ROW_LAST  = RW'(ROWS - 1);
    localparam logic [CW-1:0] c_COL_LAST  = CW'(LANE_W - 1);
    localparam logic [7:0]    c_X0        = 8'(X0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DRAW = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                     r_state;
    state_t                     w_state_next;
    logic [LANES-1:0][ROWS-1:0] r_cells;
    logic                       r_pend_tick;
    logic                       r_redraw_req;
    logic [LANES-1:0]           r_spawn_lat;
    logic [LW-1:0]              r_lane;
    logic [RW-1:0]              r_row;
    logic [CW-1:0]              r_col;

    logic                       w_last_pix;
    logic                       w_shift;
    logic                       w_start;
    logic [LANES-1:0]           w_inject;
    logic [7:0]                 w_x;
    logic                       w_cell;

    assign w_last_pix = (r_lane == c_LANE_LAST) && (r_row == c_ROW_LAST) &&
                        (r_col == c_COL_LAST);
    // A tick arriving in the shift cycle itself contributes its spawn bits.
    assign w_inject   = r_spawn_lat | (tick ? spawn : '0);
    assign w_x        = c_X0 + 8'(int'(r_lane) * X_PITCH) + 8'(r_col);
    assign w_cell     = r_cells[r_lane][r_row];

    // Next-state logic; clear overrides everything below reset.
    always_comb begin
        w_state_next = r_state;
        w_shift      = 1'b0;
        w_start      = 1'b0;
        if (clear) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_pend_tick || tick) begin
                        w_shift      = 1'b1;
                        w_start      = 1'b1;
                        w_state_next = S_DRAW;
                    end else if (r_redraw_req) begin
                        w_start      = 1'b1;
                        w_state_next = S_DRAW;
                    end
                end
                S_DRAW: begin
                    if (w_last_pix) begin
                        w_state_next = S_DONE;
                    end
                end
                S_DONE:  w_state_next = S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_cells      <= '0;
            r_pend_tick  <= 1'b0;
            r_spawn_lat  <= '0;
            r_redraw_req <= 1'b1;
            r_lane       <= '0;
            r_row        <= '0;
            r_col        <= '0;
            x            <= '0;
            y            <= '0;
            colour       <= '0;
            plot         <= 1'b0;
            frame_done   <= 1'b0;
            hit_bottom   <= '0;
            tick_overrun <= 1'b0;
        end else begin
            frame_done   <= 1'b0;
            hit_bottom   <= '0;
            tick_overrun <= 1'b0;
            if (clear) begin
                // Aborts any frame in flight; a same-cycle tick is discarded.
                r_cells      <= '0;
                r_pend_tick  <= 1'b0;
                r_spawn_lat  <= '0;
                r_redraw_req <= 1'b1;
                plot         <= 1'b0;
            end else begin
                if (tick && r_pend_tick) begin
                    tick_overrun <= 1'b1;
                end

                if (w_shift) begin
                    for (int l = 0; l < LANES; l++) begin
                        r_cells[l]    <= ROWS'({r_cells[l], w_inject[l]});
                        hit_bottom[l] <= r_cells[l][ROWS-1];
                    end
                    r_pend_tick <= 1'b0;
                    r_spawn_lat <= '0;
                end else if (tick) begin
                    // Deferred: the shift happens at the next IDLE cycle.
                    r_pend_tick <= 1'b1;
                    r_spawn_lat <= r_spawn_lat | spawn;
                end

                if (w_start && !w_shift) begin
                    r_redraw_req <= 1'b0;
                end

                if (w_start) begin
                    r_lane <= '0;
                    r_row  <= '0;
                    r_col  <= '0;
                end

                if (r_state == S_DRAW) begin
                    plot   <= 1'b1;
                    x      <= w_x;
                    y      <= 7'(r_row);
                    colour <= w_cell ? ON_COLOUR : OFF_COLOUR;
                    // Scan order: column fastest, then row, then lane.
                    if (!w_last_pix) begin
                        if (r_col == c_COL_LAST) begin
                            r_col <= '0;
                            if (r_row == c_ROW_LAST) begin
                                r_row  <= '0;
                                r_lane <= r_lane + LW'(1);
                            end else begin
                                r_row <= r_row + RW'(1);
                            end
                        end else begin
                            r_col <= r_col + CW'(1);
                        end
                    end
                end else begin
                    plot <= 1'b0;
                    if (r_state == S_DONE) begin
                        frame_done <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lane_scroll_renderer.sv
`default_nettype none
// ============================================================================
// Module      : tb_lane_scroll_renderer
// Description : Directed testbench for lane_scroll_renderer. A default-sized
//               instance covers blank frames, scrolling, overrun, clear and
//               reset; a small instance covers bottom exit in few cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lane_scroll_renderer;

    logic       clock = 1'b0;
    always #5 clock = ~clock;

    logic       resetn, tick, clear;
    logic [2:0] spawn;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot, frame_done, tick_overrun;
    logic [2:0] hit_bottom;

    logic       s_resetn, s_tick, s_clear;
    logic [2:0] s_spawn;
    logic [7:0] s_x;
    logic [6:0] s_y;
    logic [2:0] s_colour;
    logic       s_plot, s_frame_done, s_tick_overrun;
    logic [2:0] s_hit_bottom;

    lane_scroll_renderer dut (
        .clock(clock), .resetn(resetn), .tick(tick), .spawn(spawn), .clear(clear),
        .x(x), .y(y), .colour(colour), .plot(plot), .frame_done(frame_done),
        .hit_bottom(hit_bottom), .tick_overrun(tick_overrun)
    );

    lane_scroll_renderer #(
        .LANES(3), .ROWS(6), .LANE_W(2), .X0(10), .X_PITCH(4)
    ) sdut (
        .clock(clock), .resetn(s_resetn), .tick(s_tick), .spawn(s_spawn), .clear(s_clear),
        .x(s_x), .y(s_y), .colour(s_colour), .plot(s_plot), .frame_done(s_frame_done),
        .hit_bottom(s_hit_bottom), .tick_overrun(s_tick_overrun)
    );

    int         vectors = 0;
    int         miscompares = 0;
    int         n_plot = 0, n_ovr = 0, n_fd = 0;
    int         s_fd = 0, s_hb_cycles = 0, s_ovr = 0;
    logic [2:0] s_hb_val = 3'b000;
    bit         exp_cells [3][120];

    // One cycle: advance to the falling edge and tally the event outputs.
    task automatic step();
        @(negedge clock);
        if (plot)           n_plot++;
        if (tick_overrun)   n_ovr++;
        if (frame_done)     n_fd++;
        if (s_frame_done)   s_fd++;
        if (s_tick_overrun) s_ovr++;
        if (s_hit_bottom !== 3'b000) begin
            s_hb_cycles++;
            s_hb_val = s_hit_bottom;
        end
    endtask

    task automatic model_shift(input logic [2:0] inj);
        for (int l = 0; l < 3; l++) begin
            for (int r = 119; r > 0; r--) exp_cells[l][r] = exp_cells[l][r-1];
            exp_cells[l][0] = inj[l];
        end
    endtask

    task automatic model_clear();
        for (int l = 0; l < 3; l++)
            for (int r = 0; r < 120; r++) exp_cells[l][r] = 1'b0;
    endtask

    task automatic pulse_tick(input logic [2:0] sp);
        tick  = 1'b1;
        spawn = sp;
        step();
        tick  = 1'b0;
        spawn = 3'b000;
    endtask

    task automatic wait_plots(input int target, output bit ok);
        int base;
        base = n_plot;
        ok   = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (n_plot - base >= target) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic wait_frame_done(output bit ok);
        int base;
        base = n_fd;
        ok   = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            step();
            if (n_fd > base) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Collects one frame up to frame_done, scoring each pixel against the
    // expected cell map and the lane/row/column scan order.
    task automatic capture_frame(output int np, output int nbad, output int fbad,
                                 output bit done, output int fx, output int fy,
                                 output int lx, output int ly);
        int         ln, rw, cl, ex, ey;
        logic [2:0] ec;
        np = 0; nbad = 0; fbad = -1; done = 1'b0;
        fx = -1; fy = -1; lx = -1; ly = -1;
        for (int c = 0; c < 4000; c++) begin
            step();
            if (plot) begin
                ln = np / 960;
                rw = (np / 8) % 120;
                cl = np % 8;
                ex = 50 + ln * 26 + cl;
                ey = rw;
                ec = 3'b000;
                if (ln < 3) begin
                    if (exp_cells[ln][rw]) ec = 3'b100;
                end
                if (np >= 2880 || x !== 8'(ex) || y !== 7'(ey) || colour !== ec) begin
                    nbad++;
                    if (fbad < 0) fbad = np;
                end
                if (np == 0) begin
                    fx = int'(x);
                    fy = int'(y);
                end
                lx = int'(x);
                ly = int'(y);
                np++;
            end
            if (frame_done) begin
                done = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; tick = 1'b0; clear = 1'b0; spawn = 3'b000;
        s_resetn = 1'b0; s_tick = 1'b0; s_clear = 1'b0; s_spawn = 3'b000;
        repeat (3) step();
        vectors++;
        if ({x, y, colour, plot, frame_done, hit_bottom, tick_overrun} !== 24'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h expected 000000",
                     {x, y, colour, plot, frame_done, hit_bottom, tick_overrun});
        end
        vectors++;
        if ({s_x, s_y, s_colour, s_plot, s_frame_done, s_hit_bottom, s_tick_overrun} !== 24'd0) begin
            miscompares++;
            $display("FAIL reset_outputs_small: got %h expected 000000",
                     {s_x, s_y, s_colour, s_plot, s_frame_done, s_hit_bottom, s_tick_overrun});
        end
        resetn   = 1'b1;
        s_resetn = 1'b1;
    endtask

    task automatic test_blank_frame();
        int np, nbad, fbad, fx, fy, lx, ly, base;
        bit done;
        capture_frame(np, nbad, fbad, done, fx, fy, lx, ly);
        vectors++;
        if (np !== 2880) begin miscompares++; $display("FAIL blank_plots: got %0d expected 2880", np); end
        vectors++;
        if (nbad !== 0) begin miscompares++; $display("FAIL blank_pixels: got %0d bad (first %0d) expected 0", nbad, fbad); end
        vectors++;
        if (fx !== 50 || fy !== 0) begin miscompares++; $display("FAIL blank_first: got (%0d,%0d) expected (50,0)", fx, fy); end
        vectors++;
        if (lx !== 109 || ly !== 119) begin miscompares++; $display("FAIL blank_last: got (%0d,%0d) expected (109,119)", lx, ly); end
        vectors++;
        if (done !== 1'b1) begin miscompares++; $display("FAIL blank_frame_done: got %0d expected 1", done); end
        base = n_plot;
        repeat (100) step();
        vectors++;
        if (n_plot !== base) begin miscompares++; $display("FAIL blank_idle_plots: got %0d expected 0", n_plot - base); end
    endtask

    task automatic test_scroll();
        int np, nbad, fbad, fx, fy, lx, ly, tot;
        bit done;
        tot = 0;
        pulse_tick(3'b001);
        model_shift(3'b001);
        capture_frame(np, nbad, fbad, done, fx, fy, lx, ly);
        tot += nbad + ((np != 2880) ? 1 : 0) + (done ? 0 : 1);
        for (int k = 0; k < 5; k++) begin
            pulse_tick(3'b000);
            model_shift(3'b000);
            capture_frame(np, nbad, fbad, done, fx, fy, lx, ly);
            if (k < 4) tot += nbad + ((np != 2880) ? 1 : 0) + (done ? 0 : 1);
        end
        vectors++;
        if (tot !== 0) begin miscompares++; $display("FAIL scroll_intermediate: got %0d errors expected 0", tot); end
        vectors++;
        if (np !== 2880 || done !== 1'b1) begin miscompares++; $display("FAIL scroll_final_len: got %0d plots done=%0d expected 2880 done=1", np, done); end
        vectors++;
        if (nbad !== 0) begin miscompares++; $display("FAIL scroll_final_pixels: got %0d bad (first %0d) expected 0", nbad, fbad); end
    endtask

    task automatic test_bottom_exit();
        int         on_cnt [7];
        int         sp, base;
        logic [2:0] hb6;
        hb6 = 3'b000;
        sp  = 0;
        s_hb_cycles = 0;
        for (int k = 0; k < 7; k++) begin
            s_tick  = 1'b1;
            s_spawn = (k == 0) ? 3'b100 : 3'b000;
            step();
            s_tick  = 1'b0;
            s_spawn = 3'b000;
            if (k == 6) hb6 = s_hit_bottom;
            on_cnt[k] = 0;
            sp   = 0;
            base = s_fd;
            for (int c = 0; c < 200; c++) begin
                if (s_fd != base) break;
                step();
                if (s_plot) begin
                    sp++;
                    if (s_colour === 3'b100) on_cnt[k]++;
                end
            end
        end
        vectors++;
        if (hb6 !== 3'b100) begin miscompares++; $display("FAIL bottom_hit_value: got %b expected 100", hb6); end
        vectors++;
        if (s_hb_cycles !== 1 || s_hb_val !== 3'b100) begin miscompares++; $display("FAIL bottom_hit_pulses: got %0d cycles last %b expected 1 cycle 100", s_hb_cycles, s_hb_val); end
        for (int k = 0; k < 6; k++) begin
            vectors++;
            if (on_cnt[k] !== 2) begin miscompares++; $display("FAIL bottom_on_frame%0d: got %0d expected 2", k, on_cnt[k]); end
        end
        vectors++;
        if (on_cnt[6] !== 0 || sp !== 36) begin miscompares++; $display("FAIL bottom_final_frame: got on=%0d plots=%0d expected on=0 plots=36", on_cnt[6], sp); end
        vectors++;
        if (s_ovr !== 0) begin miscompares++; $display("FAIL bottom_overrun: got %0d expected 0", s_ovr); end
    endtask

    task automatic test_overrun();
        int np, nbad, fbad, fx, fy, lx, ly, ob, base;
        bit done, ok1, ok2, ok3;
        ob = n_ovr;
        pulse_tick(3'b000);
        model_shift(3'b000);
        wait_plots(100, ok1);
        pulse_tick(3'b001);
        wait_plots(400, ok2);
        pulse_tick(3'b010);
        wait_frame_done(ok3);
        vectors++;
        if ({ok1, ok2, ok3} !== 3'b111) begin miscompares++; $display("FAIL overrun_progress: got %b expected 111", {ok1, ok2, ok3}); end
        vectors++;
        if (n_ovr - ob !== 1) begin miscompares++; $display("FAIL overrun_pulses: got %0d expected 1", n_ovr - ob); end
        model_shift(3'b011);
        capture_frame(np, nbad, fbad, done, fx, fy, lx, ly);
        vectors++;
        if (np !== 2880 || done !== 1'b1) begin miscompares++; $display("FAIL overrun_frame_len: got %0d plots done=%0d expected 2880 done=1", np, done); end
        vectors++;
        if (nbad !== 0) begin miscompares++; $display("FAIL overrun_frame_pixels: got %0d bad (first %0d) expected 0", nbad, fbad); end
        base = n_plot;
        repeat (50) step();
        vectors++;
        if (n_plot !== base) begin miscompares++; $display("FAIL overrun_single_shift: got %0d extra plots expected 0", n_plot - base); end
    endtask

    task automatic test_clear();
        int np, nbad, fbad, fx, fy, lx, ly, fdb, ob, base;
        bit done, ok1, ok2;
        fdb = n_fd;
        ob  = n_ovr;
        pulse_tick(3'b000);
        model_shift(3'b000);
        wait_plots(500, ok1);
        pulse_tick(3'b000);           // leaves a tick pending that clear must drop
        wait_plots(499, ok2);
        clear = 1'b1; tick = 1'b1; spawn = 3'b111;
        step();
        clear = 1'b0; tick = 1'b0; spawn = 3'b000;
        vectors++;
        if (plot !== 1'b0) begin miscompares++; $display("FAIL clear_plot: got %b expected 0", plot); end
        vectors++;
        if (n_fd !== fdb || n_ovr !== ob || {ok1, ok2} !== 2'b11) begin
            miscompares++;
            $display("FAIL clear_events: got fd=%0d ovr=%0d ok=%b expected 0 0 11", n_fd - fdb, n_ovr - ob, {ok1, ok2});
        end
        model_clear();
        capture_frame(np, nbad, fbad, done, fx, fy, lx, ly);
        vectors++;
        if (np !== 2880 || done !== 1'b1) begin miscompares++; $display("FAIL clear_frame_len: got %0d plots done=%0d expected 2880 done=1", np, done); end
        vectors++;
        if (nbad !== 0) begin miscompares++; $display("FAIL clear_frame_pixels: got %0d bad (first %0d) expected 0", nbad, fbad); end
        base = n_plot;
        repeat (50) step();
        vectors++;
        if (n_plot !== base) begin miscompares++; $display("FAIL clear_pending_dropped: got %0d extra plots expected 0", n_plot - base); end
    endtask

    task automatic test_reset_mid_draw();
        int np, nbad, fbad, fx, fy, lx, ly;
        bit done, ok;
        pulse_tick(3'b101);
        model_shift(3'b101);
        wait_plots(300, ok);
        resetn = 1'b0;
        step();
        vectors++;
        if (!ok || {x, y, colour, plot, frame_done, hit_bottom, tick_overrun} !== 24'd0) begin
            miscompares++;
            $display("FAIL middraw_reset_outputs: got %h ok=%0d expected 000000 ok=1",
                     {x, y, colour, plot, frame_done, hit_bottom, tick_overrun}, ok);
        end
        resetn = 1'b1;
        model_clear();
        capture_frame(np, nbad, fbad, done, fx, fy, lx, ly);
        vectors++;
        if (np !== 2880 || done !== 1'b1) begin miscompares++; $display("FAIL middraw_frame_len: got %0d plots done=%0d expected 2880 done=1", np, done); end
        vectors++;
        if (nbad !== 0) begin miscompares++; $display("FAIL middraw_frame_pixels: got %0d bad (first %0d) expected 0", nbad, fbad); end
        vectors++;
        if (fx !== 50 || fy !== 0 || lx !== 109 || ly !== 119) begin
            miscompares++;
            $display("FAIL middraw_corners: got (%0d,%0d)..(%0d,%0d) expected (50,0)..(109,119)", fx, fy, lx, ly);
        end
    endtask

    initial begin
        test_reset();
        test_blank_frame();
        test_scroll();
        test_bottom_exit();
        test_overrun();
        test_clear();
        test_reset_mid_draw();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lane_scroll_renderer.md
Name: lane_scroll_renderer

Overview:
Parametrised successor to the fixed three-lane falling-strip display. Holds LANES vertical bit-columns of ROWS cells each. On every scroll tick it shifts all lanes down one row and injects new cells at the top. It then streams one full frame of pixel writes (x, y, colour, plot) to the VGA adapter. Adds deferred/overrun tick handling, bottom-exit reporting, clear, and frame-done signalling.

Parameters:
LANES, 3, number of lanes (1..8)
ROWS, 120, cells per lane; cell r drawn at y=r (1..120)
LANE_W, 8, pixel width of a lane (1..16)
X0, 50, x of lane 0 column 0
X_PITCH, 26, x distance between lane origins
ON_COLOUR, 3'b100, colour of an occupied cell
OFF_COLOUR, 3'b000, colour of an empty cell
Legality: X0+(LANES-1)*X_PITCH+LANE_W-1 <= 159 and X_PITCH >= LANE_W; violations are a configuration error, no runtime check.

Ports:
clock  in  1  system clock
resetn  in  1  synchronous active-low reset
tick  in  1  one-cycle scroll strobe
spawn  in  LANES  cells to inject at row 0; sampled only in a cycle where tick=1
clear  in  1  one-cycle request to empty all lanes and redraw
x  out  8  pixel x
y  out  7  pixel y
colour  out  3  pixel colour
plot  out  1  pixel write enable
frame_done  out  1  one-cycle pulse after the last pixel of a frame
hit_bottom  out  LANES  one-cycle pulse per lane whose row ROWS-1 was 1 when shifted out
tick_overrun  out  1  one-cycle pulse when a tick is dropped

Behaviour:
- Reset (resetn=0 at an edge): all lane cells=0; state=IDLE; x=0, y=0, colour=0, plot=0, frame_done=0, hit_bottom=0, tick_overrun=0; pend_tick=0; spawn_lat=0; redraw_req=1, so a blank frame is drawn after reset without a shift. Reset has priority over everything, including mid-DRAW.
- Priority below reset: clear > tick.
- tick handling: on a tick edge, spawn_lat <= spawn_lat | spawn.
  - If pend_tick=0: pend_tick <= 1.
  - If pend_tick=1 already: tick_overrun pulses, no second shift, spawn still ORed in.
- States:
  - IDLE: if clear -> see clear. Else if pend_tick (or tick this cycle) -> shift (for every lane: cell[r] <= cell[r-1] for r>0, cell[0] <= spawn_lat bit, which includes a same-cycle spawn); hit_bottom <= old cell[ROWS-1]; clear pend_tick and spawn_lat; go to DRAW with lane=row=col=0. Else if redraw_req -> clear it, go to DRAW, no shift.
  - DRAW: every edge registers one pixel, plot=1.
    - x = X0 + lane*X_PITCH + col; y = row.
    - colour = ON_COLOUR if cell(lane,row) else OFF_COLOUR.
    - Scan order: col fastest, then row, then lane.
    - After pixel (LANES-1, ROWS-1, LANE_W-1), go to DONE.
    - Lanes never change during DRAW; ticks only set pend_tick.
  - DONE: plot=0, frame_done=1 for exactly this cycle, then IDLE. A pending tick therefore shifts on the next IDLE edge.
- Frame length N = LANES*ROWS*LANE_W plot cycles (defaults: 2880). Latency from tick edge in IDLE (shift edge) to first plot=1 is one edge. Total frame cost is N+2 cycles including IDLE and DONE.
- clear, in any state: all cells=0, pend_tick=0, spawn_lat=0, redraw_req=1, state=IDLE, plot=0 from the next edge. An in-flight frame is aborted with no frame_done. A tick in the same cycle as clear is discarded, with no overrun.
- hit_bottom and tick_overrun are zero in every cycle they are not pulsing. x, y, and colour hold their last values when plot=0.
- Counter widths: lane/row/col counters sized by clog2 of the parameter; x arithmetic done in 8 bits; no wrap past 159 for legal parameters.

Test Plan:
1. Release reset, no ticks -> exactly 2880 plots, all colour 000; first (50,0), last (109,119); one frame_done; then plot stays 0.
2. tick with spawn=3'b001, then 5 ticks with spawn=0, each after frame_done -> final frame: x 50..57, y=5 colour 100; all other pixels 000.
3. tick with spawn=3'b100, then 120 further ticks -> hit_bottom=3'b100 for one cycle on the 120th subsequent shift edge; next frame all 000.
4. Two ticks during one DRAW (spawn=001 then 010) -> one tick_overrun pulse; a single shift after frame_done; row 0 shows lanes 0 and 1 set.
5. clear at pixel 1000 of a frame with occupied cells -> plot 0 next edge, no frame_done for the aborted frame; a fresh blank 2880-pixel frame follows.
6. resetn=0 mid-DRAW -> next edge: plot=0 and all outputs at reset values; after release one blank frame (as test 1).
